// File: rtl/capture_pkg.sv
// Shared types and default constants for the frame-capture controller and its SPI ADC receiver.
package capture_pkg;

  typedef enum logic [2:0] {
    CS_IDLE,
    CS_SETTLE,
    CS_CONVERT,
    CS_WRITE,
    CS_DONE
  } cap_state_e;

  localparam int unsigned DEF_ROWS       = 112;
  localparam int unsigned DEF_COLS       = 112;
  localparam int unsigned DEF_CLK_DIV    = 4;
  localparam int unsigned DEF_SPI_BITS   = 16;
  localparam int unsigned DEF_PIX_W      = 12;
  localparam int unsigned DEF_SETTLE_CYC = 8;
  localparam int unsigned DEF_ADDR_W     = 14;

  // Counter width that stays at least one bit for degenerate counts.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_adc_rx.sv
// SPI mode-0 receiver for one ADC conversion: clock divider, bit counter and sample shifter.
module spi_adc_rx
  import capture_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned SPI_BITS = DEF_SPI_BITS,
  parameter int unsigned PIX_W    = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             go,
  input  logic             abort,
  input  logic             miso,
  output logic             cs,
  output logic             SPI_CLK,
  output logic [PIX_W-1:0] sample,
  output logic             ready
);

  localparam int unsigned DivW = cnt_width(CLK_DIV);
  localparam int unsigned BitW = cnt_width(SPI_BITS);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(SPI_BITS - 1);

  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [PIX_W-1:0] shift_q, shift_d;
  logic             ready_q, ready_d;

  always_comb begin
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (abort) begin
      cs_d   = 1'b1;
      sclk_d = 1'b0;
    end else if (cs_q) begin
      if (go) begin
        cs_d   = 1'b0;
        sclk_d = 1'b0;
        div_d  = '0;
        bit_d  = '0;
      end
    end else if (div_q != DivLast) begin
      div_d = div_q + DivW'(1);
    end else begin
      div_d = '0;
      if (!sclk_q) begin
        sclk_d  = 1'b1;
        shift_d = {shift_q[PIX_W-2:0], miso};
      end else begin
        sclk_d = 1'b0;
        if (bit_q == BitLast) begin
          cs_d = 1'b1;
        end else begin
          bit_d = bit_q + BitW'(1);
        end
      end
    end
    // Flag the final cs-low cycle so the parent can register the write on the same edge cs rises.
    ready_d = !cs_d && sclk_d && (bit_d == BitLast) && (div_d == DivLast);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ready_q <= 1'b0;
    end else begin
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
    end
  end

  assign cs      = cs_q;
  assign SPI_CLK = sclk_q;
  assign sample  = shift_q;
  assign ready   = ready_q;

endmodule

// File: rtl/capture_sequencer.sv
// Frame-capture controller: walks the pixel array, settles, converts via SPI ADC, writes the buffer.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned SPI_BITS   = DEF_SPI_BITS,
  parameter int unsigned PIX_W      = DEF_PIX_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       RESET,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       miso,
  output logic                       cs,
  output logic                       SPI_CLK,
  output logic [cnt_width(ROWS)-1:0] row_sel,
  output logic [cnt_width(COLS)-1:0] col_sel,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [PIX_W-1:0]           wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       startCaptureTP,
  output logic [7:0]                 frame_count
);

  localparam int unsigned RowW = cnt_width(ROWS);
  localparam int unsigned ColW = cnt_width(COLS);
  localparam int unsigned SetW = cnt_width(SETTLE_CYC);
  localparam logic [RowW-1:0] RowLast    = RowW'(ROWS - 1);
  localparam logic [ColW-1:0] ColLast    = ColW'(COLS - 1);
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYC - 1);

  cap_state_e       state_q, state_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0] wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tp_q, tp_d;
  logic [7:0]       fc_q, fc_d;

  logic             go;
  logic             rx_ready;
  logic [PIX_W-1:0] rx_sample;

  spi_adc_rx #(
    .CLK_DIV (CLK_DIV),
    .SPI_BITS(SPI_BITS),
    .PIX_W   (PIX_W)
  ) u_rx (
    .clk    (clk),
    .RESET  (RESET),
    .go     (go),
    .abort  (abort),
    .miso   (miso),
    .cs     (cs),
    .SPI_CLK(SPI_CLK),
    .sample (rx_sample),
    .ready  (rx_ready)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    settle_d  = settle_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tp_d      = 1'b0;
    fc_d      = fc_q;
    go        = 1'b0;
    if (abort && (state_q != CS_IDLE)) begin
      state_d = CS_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        CS_IDLE: begin
          if (start && !abort) begin
            state_d  = CS_SETTLE;
            row_d    = '0;
            col_d    = '0;
            addr_d   = '0;
            settle_d = '0;
            busy_d   = 1'b1;
            tp_d     = 1'b1;
          end
        end
        CS_SETTLE: begin
          if (settle_q == SettleLast) begin
            go      = 1'b1;
            state_d = CS_CONVERT;
          end else begin
            settle_d = settle_q + SetW'(1);
          end
        end
        CS_CONVERT: begin
          if (rx_ready) begin
            state_d   = CS_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx_sample;
          end
        end
        CS_WRITE: begin
          if ((row_q == RowLast) && (col_q == ColLast)) begin
            state_d = CS_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            fc_d    = fc_q + 8'd1;
          end else begin
            state_d  = CS_SETTLE;
            settle_d = '0;
            // Running address tracks row*COLS+col without a multiplier.
            addr_d   = addr_q + ADDR_W'(1);
            if (col_q == ColLast) begin
              col_d = '0;
              row_d = row_q + RowW'(1);
            end else begin
              col_d = col_q + ColW'(1);
            end
          end
        end
        CS_DONE: state_d = CS_IDLE;
        default: state_d = CS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= CS_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      settle_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tp_q      <= 1'b0;
      fc_q      <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      settle_q  <= settle_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tp_q      <= tp_d;
      fc_q      <= fc_d;
    end
  end

  assign row_sel        = row_q;
  assign col_sel        = col_q;
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign startCaptureTP = tp_q;
  assign frame_count    = fc_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized scoreboard bench for capture_sequencer on the small 2x3 configuration.
module tb_capture_sequencer;

  localparam int unsigned ROWS       = 2;
  localparam int unsigned COLS       = 3;
  localparam int unsigned CLK_DIV    = 1;
  localparam int unsigned SPI_BITS   = 16;
  localparam int unsigned PIX_W      = 12;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned ADDR_W     = 14;
  localparam int unsigned NPIX       = ROWS * COLS;
  localparam int unsigned CONV_CYC   = 2 * CLK_DIV * SPI_BITS;
  localparam int unsigned PIX_CYC    = SETTLE_CYC + CONV_CYC + 1;
  localparam int unsigned FRAME_LAT  = NPIX * PIX_CYC + 2;
  localparam int unsigned RW         = $clog2(ROWS);
  localparam int unsigned CW         = $clog2(COLS);
  localparam int unsigned OUTW       = 1 + 1 + RW + CW + 1 + ADDR_W + PIX_W + 1 + 1 + 1 + 8;
  localparam logic [OUTW-1:0] RST_VEC = {1'b1, {(OUTW - 1){1'b0}}};

  logic              clk = 1'b0;
  logic              RESET, start, abort, miso;
  logic              cs, SPI_CLK, wr_en, busy, done, startCaptureTP;
  logic [RW-1:0]     row_sel;
  logic [CW-1:0]     col_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic [7:0]        frame_count;

  capture_sequencer #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .CLK_DIV   (CLK_DIV),
    .SPI_BITS  (SPI_BITS),
    .PIX_W     (PIX_W),
    .SETTLE_CYC(SETTLE_CYC),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk           (clk),
    .RESET         (RESET),
    .start         (start),
    .abort         (abort),
    .miso          (miso),
    .cs            (cs),
    .SPI_CLK       (SPI_CLK),
    .row_sel       (row_sel),
    .col_sel       (col_sel),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .startCaptureTP(startCaptureTP),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pix_idx = 0;
  int   frame_writes = 0;
  int   tp_count = 0;
  int   done_count = 0;
  int   fc_model = 0;
  bit   rand_data = 1'b0;
  bit   cut = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [OUTW-1:0] out_vec();
    return {cs, SPI_CLK, row_sel, col_sel, wr_en, wr_addr, wr_data, busy, done, startCaptureTP,
            frame_count};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ADC model: serves a word per conversion, checks the SPI framing, queues the expected write.
  logic                cs_prev = 1'b1;
  logic                sclk_prev = 1'b0;
  logic [SPI_BITS-1:0] word = '0;
  logic [RW+CW-1:0]    sel_exp = '0;
  int                  nrise = 0;
  int                  low_cyc = 0;
  int                  first_off = -1;
  bit                  sel_bad = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (cs === 1'b0 && cs_prev === 1'b1) begin
        word = rand_data ? SPI_BITS'($urandom) : SPI_BITS'(16'h0AB0 + pix_idx);
        sel_exp = {RW'(pix_idx / COLS), CW'(pix_idx % COLS)};
        check("sel_at_cs_fall", {row_sel, col_sel}, sel_exp);
        exp_q.push_back('{addr: pix_idx, data: int'(word[PIX_W-1:0])});
        pix_idx++;
        nrise = 0;
        low_cyc = 0;
        first_off = -1;
        sel_bad = 1'b0;
      end
      if (cs === 1'b0) begin
        low_cyc++;
        if (SPI_CLK === 1'b1 && sclk_prev === 1'b0) begin
          nrise++;
          if (nrise == 1) first_off = low_cyc - 1;
        end
        if ({row_sel, col_sel} !== sel_exp) sel_bad = 1'b1;
        miso = (nrise < int'(SPI_BITS)) ? word[SPI_BITS-1-nrise] : 1'b0;
      end
      if (cs === 1'b1 && cs_prev === 1'b0) begin
        if (cut) begin
          cut = 1'b0;
        end else begin
          check("cs_low_cycles", low_cyc, CONV_CYC);
          check("sclk_rises", nrise, SPI_BITS);
          check("first_rise_offset", first_off, CLK_DIV);
          check("sel_stable_in_conv", sel_bad, 0);
        end
      end
      cs_prev = cs;
      sclk_prev = SPI_CLK;
    end
  end

  // Write monitor: pops the scoreboard whenever the DUT strobes the buffer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        frame_writes++;
        if (exp_q.size() == 0) begin
          fail("unexpected_write", $sformatf("got write addr %0d data 0x%0h, required none",
                                             wr_addr, wr_data));
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
      end
      if (startCaptureTP === 1'b1) tp_count++;
      if (done === 1'b1) done_count++;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy !== 1'b0 || done !== 1'b0) && n < 50);
    if (n >= 50) fail("idle_wait", "got busy/done stuck, required idle");
  endtask

  task automatic kick(input bit rnd);
    wait_idle();
    rand_data = rnd;
    pix_idx = 0;
    frame_writes = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input int extra_start);
    int  start_cyc, tp0, done0;
    bit  seen;
    wait_idle();
    rand_data = rnd;
    pix_idx = 0;
    frame_writes = 0;
    tp0 = tp_count;
    done0 = done_count;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check("tp_busy_after_start", {startCaptureTP, busy}, 2'b11);
    seen = 1'b0;
    for (int n = 1; n <= int'(FRAME_LAT) + 20; n++) begin
      start = (extra_start > 0 && n == extra_start);
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) begin
      fail("done_timeout", "got no done, required done within frame budget");
    end else begin
      // Count is inclusive of the start-request cycle and the done cycle.
      check("done_latency", cyc - start_cyc + 1, FRAME_LAT);
      fc_model = (fc_model + 1) % 256;
      check("busy_at_done", busy, 1'b0);
      check("frame_count", frame_count, fc_model);
      check("frame_writes", frame_writes, NPIX);
      @(negedge clk);
      check("done_pulses", done_count - done0, 1);
      check("tp_pulses", tp_count - tp0, 1);
    end
  endtask

  initial begin
    int n, d0;
    RESET = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    miso = 1'b0;
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    check("reset_state", out_vec(), RST_VEC);

    // Fixed ADC pattern, then a frame with an ignored mid-frame start.
    run_frame(1'b0, 0);
    run_frame(1'b1, 50);

    // Abort somewhere inside pixel 2's conversion.
    kick(1'b1);
    d0 = done_count;
    n = 0;
    while (pix_idx < 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("abort_wait", "got no pixel-2 conversion, required one");
    repeat ($urandom_range(0, 25)) @(negedge clk);
    abort = 1'b1;
    cut = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outputs", {cs, SPI_CLK, busy}, 3'b100);
    repeat (PIX_CYC + 5) @(negedge clk);
    check("abort_writes", frame_writes, 2);
    check("abort_no_done", done_count - d0, 0);
    check("abort_frame_count", frame_count, fc_model);
    check("abort_pending", exp_q.size(), 1);
    exp_q.delete();
    run_frame(1'b1, 0);

    // Reset pulse during pixel 1's settle window.
    kick(1'b1);
    n = 0;
    while (frame_writes < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("reset_wait", "got no first write, required one");
    @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    check("reset_mid_frame", out_vec(), RST_VEC);
    check("reset_pending", exp_q.size(), 0);
    exp_q.delete();
    fc_model = 0;

    for (int f = 0; f < 256; f++) run_frame(1'b1, 0);
    check("frame_count_wrap", frame_count, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Frame-capture controller for the fabric side of the capture design.
- On a start request from the MSS it walks the sensor pixel array row by row, selecting each pixel.
- For each pixel it waits a settle time, reads one SPI ADC conversion (`cs`/`SPI_CLK`/`miso`) and writes the sample into the pixel buffer.
- It drives the `startCaptureTP` test point and reports busy/done/frame count back to the MSS registers.

## Interface
Parameters:
- `ROWS`, 112: sensor rows per frame.
- `COLS`, 112: sensor columns per frame.
- `CLK_DIV`, 4: `SPI_CLK` half-period, in `clk` cycles (≥1).
- `SPI_BITS`, 16: bits per ADC conversion frame.
- `PIX_W`, 12: sample width; the sample is the last `PIX_W` bits shifted in.
- `SETTLE_CYC`, 8: wait after a pixel-select change before the conversion starts (≥1).
- `ADDR_W`, 14: buffer address width; `ROWS*COLS` must be ≤ 2^ADDR_W.

Ports (name, direction, width, meaning):
- `clk` in 1: fabric clock (the only clock).
- `RESET` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle frame-capture request.
- `abort` in 1: terminate the capture in progress.
- `miso` in 1: ADC serial data.
- `cs` out 1: ADC chip select, active low. Reset 1.
- `SPI_CLK` out 1: ADC serial clock, idle low. Reset 0.
- `row_sel` out $clog2(ROWS): sensor row select. Reset 0.
- `col_sel` out $clog2(COLS): sensor column select. Reset 0.
- `wr_en` out 1: pixel buffer write strobe. Reset 0.
- `wr_addr` out ADDR_W: buffer address. Reset 0.
- `wr_data` out PIX_W: pixel sample. Reset 0.
- `busy` out 1: frame capture in progress. Reset 0.
- `done` out 1: one-cycle pulse when a frame completes. Reset 0.
- `startCaptureTP` out 1: one-cycle pulse when a frame starts. Reset 0.
- `frame_count` out 8: count of completed frames, wraps. Reset 0.

## Operation
- States: IDLE, SETTLE, CONVERT, WRITE, DONE.
- **IDLE**
  - `start`=1 and `abort`=0 → SETTLE.
  - On that transition: `row_sel`=`col_sel`=0, `busy`=1, `startCaptureTP` pulses.
- **SETTLE**: lasts exactly `SETTLE_CYC` cycles, then → CONVERT.
- **CONVERT**
  - `cs`=0 for exactly 2·`CLK_DIV`·`SPI_BITS` cycles.
  - `SPI_CLK` is low for the first `CLK_DIV` cycles of each bit, then high for `CLK_DIV` cycles (SPI mode 0).
  - `miso` is shifted in MSB-first on each `SPI_CLK` rising transition.
  - → WRITE.
- **WRITE** (1 cycle)
  - `cs`=1, `wr_en`=1, `wr_addr`=row·COLS+col, `wr_data`=last `PIX_W` shifted bits.
  - Then advance: increment col; on col=COLS-1, col←0 and row++.
  - Not the last pixel → SETTLE with the new `row_sel`/`col_sel` visible from the first SETTLE cycle.
  - Last pixel (row=ROWS-1, col=COLS-1) → DONE.
- **DONE** (1 cycle)
  - `done`=1, `busy`=0, `frame_count`++ (255→0). → IDLE.
- `start` while `busy`=1 is ignored (not queued).
- `abort` in any non-IDLE state → IDLE on the next edge.
  - `cs`=1, `SPI_CLK`=0, `busy`=0.
  - No `done`, no further `wr_en`, `frame_count` unchanged.
  - `abort` has priority over `start`, and over the WRITE in the same cycle (that write is suppressed).
- `RESET` mid-frame: all outputs and state return to reset values at the next edge; the partial frame is discarded.

## Timing
- Per pixel: `SETTLE_CYC` + 2·`CLK_DIV`·`SPI_BITS` + 1 cycles. Defaults: 8+128+1 = 137.
- Per frame: `ROWS`·`COLS`·per-pixel + 2 cycles (start edge to `done`).
- `startCaptureTP` and `busy` rise in the cycle after `start` is sampled.
- `done` occurs the cycle after the last WRITE.
- `cs` falls in the first CONVERT cycle and rises in the WRITE cycle.
- The first `SPI_CLK` rise is `CLK_DIV` cycles after `cs` falls.
- All outputs are registered; no combinational paths from inputs to outputs.

## Structure
- Shared package `capture_pkg`: state enum (`CS_IDLE`, `CS_SETTLE`, `CS_CONVERT`, `CS_WRITE`, `CS_DONE`) and default parameter constants.
- Sub-module `spi_adc_rx` holds the `CLK_DIV` divider, bit counter and shift register.
  - Interface: `go` in, `cs`/`SPI_CLK`/`miso`, `sample` out, `ready` pulse out, `abort` in.
- Parent `capture_sequencer` owns the FSM, row/column counters, address generation, settle counter and frame counter.

## Test plan
Small configuration for all scenarios: ROWS=2, COLS=3, CLK_DIV=1, SETTLE_CYC=2, SPI_BITS=16, PIX_W=12.
- **Full frame**
  - Stimulus: ADC model returns 0x0AB0+pixel index.
  - Required: 6 writes, addr 0..5, data 0xAB0..0xAB5 (low 12 bits).
  - Required: `done` at cycle 6·35+2 = 212 after `start`; `frame_count`=1.
- **SPI waveform**
  - Stimulus: one conversion in the full-frame run.
  - Required: `cs` low for exactly 32 cycles.
  - Required: 16 `SPI_CLK` rising edges, first rise 1 cycle after `cs` falls.
  - Required: `row_sel`/`col_sel` stable while `cs`=0.
- **Start while busy**
  - Stimulus: `start` pulse at cycle 50 of a frame.
  - Required: frame unchanged, exactly one `done`, one `startCaptureTP`.
- **Abort mid-conversion**
  - Stimulus: `abort` during pixel 2's CONVERT.
  - Required: next cycle `cs`=1, `SPI_CLK`=0, `busy`=0.
  - Required: only addrs 0,1 written, no `done`, `frame_count` unchanged.
  - Required: a following `start` captures a full frame.
- **Reset mid-frame**
  - Stimulus: `RESET` high 1 cycle mid-SETTLE.
  - Required: all outputs at reset values the next cycle.
- **Frame count wrap**
  - Stimulus: 256 back-to-back frames.
  - Required: `frame_count` reads 0 after the 256th `done`.
